gate_bist_checker: RTL and testbench
====================================

GATE_BIST_CHECKER -- requirements
Module: gate_bist_checker

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 Parameter: SETTLE_CYCLES, default 2, number of cycles each input vector is held before outputs are sampled; legal range 1..15.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  begin a test run; sampled only in IDLE.
REQ-006 Port: a_out  output  1  gate input a, driven to the gate under test.
REQ-007 Port: b_out  output  1  gate input b, driven to the gate under test.
REQ-008 Port: y_in  input  7  gate outputs from the gate under test. Bit mapping: y_in[0]=AND, [1]=OR, [2]=NAND, [3]=NOR, [4]=XOR, [5]=XNOR, [6]=NOT a.
REQ-009 Port: busy  output  1  high while a run is in progress.
REQ-010 Port: done  output  1  one-cycle pulse when a run completes.
REQ-011 Port: pass  output  1  high when the last completed run had zero mismatching vectors.
REQ-012 Port: err_count  output  3  number of failing vectors in the last run (0..4).
REQ-013 Port: err_vec  output  7  sticky OR of the mismatching y_in bit positions over the run.
REQ-014 Port: fail_pattern  output  4  bit k set when vector k failed; vector k is {a,b}=k, i.e. 00, 01, 10, 11.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, CHECK and FINISH.
REQ-016 In IDLE, with start=1 at an edge: clear err_count, err_vec, fail_pattern and pass; set vector index to 0; drive a_out=0, b_out=0; set busy=1; load the settle counter; go to SETTLE.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-018 CHECK SHALL last exactly one cycle and SHALL compare y_in against the expected 7-bit truth-table word for the current {a_out,b_out}.
REQ-019 On a mismatch in CHECK: err_count += 1, err_vec |= (y_in XOR expected), and fail_pattern[index] = 1.
REQ-020 In CHECK with index < 3: increment index, drive the new {a_out,b_out}=index, reload the counter and go to SETTLE.
REQ-021 In CHECK with index = 3: go to FINISH.
REQ-022 In FINISH: done=1 for exactly one cycle; pass=(err_count==0); busy=0; a_out=b_out=0; go to IDLE.
REQ-023 Latency: done SHALL be high in the cycle following edge 4*(SETTLE_CYCLES+1) counted from the edge that sampled start. With the default this is edge 12.
REQ-024 start while busy=1, or during FINISH, SHALL be ignored and SHALL NOT restart or extend the run.
REQ-025 pass, err_count, err_vec and fail_pattern SHALL hold their values from FINISH until the next accepted start.
REQ-026 a_out and b_out SHALL be registered and SHALL change only on the edge that enters a vector's SETTLE.
REQ-027 y_in SHALL be sampled only in CHECK; y_in values at any other time SHALL have no effect.

Reset
REQ-028 While rst_n=0, the block SHALL be in IDLE with a_out, b_out, busy, done, pass, err_count, err_vec, fail_pattern and the internal counters all at 0.
REQ-029 Reset asserted mid-run SHALL abort the run immediately with no done pulse, and a start after reset release SHALL begin a clean run.

Verification
REQ-030 A correct gate model on y_in, SETTLE_CYCLES=2, start pulse -> a_out/b_out step 00,01,10,11 every 3 cycles; done at edge 12; pass=1; err_count=0; err_vec=0; fail_pattern=0000.
REQ-031 y_in[0] stuck at 0 -> only vector 11 fails; err_count=1, err_vec=0000001, fail_pattern=1000, pass=0.
REQ-032 y_in[6] inverted -> all vectors fail; err_count=4, err_vec=1000000, fail_pattern=1111, pass=0.
REQ-033 start re-pulsed at edges 3 and 12 during a run -> no restart; exactly one done, at edge 12.
REQ-034 rst_n pulled low at edge 5 of a run -> all outputs 0 with no done; a new start after release gives a clean pass.
REQ-035 SETTLE_CYCLES=1, correct model -> vectors change every 2 cycles; done at edge 8; pass=1.

Source files
------------

// File: rtl/gate_bist_checker.sv
// rtl/gate_bist_checker.sv - exhaustive two-input gate BIST sequencer and checker
// Steps {a,b} through 00..11, compares seven gate outputs against their truth table.
module gate_bist_checker #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a_out,
   output logic       b_out,
   input  logic [6:0] y_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [6:0] err_vec,
   output logic [3:0] fail_pattern
);

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, FINISH} state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [3:0] cnt;
   logic [1:0] idx;
   logic [6:0] expected;
   logic [6:0] diff;
   logic       mismatch;
   logic [2:0] err_next;

   // Reference word built from the gate equations so it tracks the y_in bit map directly.
   always_comb begin
      expected = {~a_out, ~(a_out ^ b_out), a_out ^ b_out, ~(a_out | b_out),
                  ~(a_out & b_out), a_out | b_out, a_out & b_out};
      diff     = y_in ^ expected;
      mismatch = |diff;
      err_next = err_count + {2'b00, mismatch};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         idx          <= 2'd0;
         a_out        <= 1'b0;
         b_out        <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         err_count    <= 3'd0;
         err_vec      <= 7'd0;
         fail_pattern <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  err_count    <= 3'd0;
                  err_vec      <= 7'd0;
                  fail_pattern <= 4'd0;
                  pass         <= 1'b0;
                  idx          <= 2'd0;
                  a_out        <= 1'b0;
                  b_out        <= 1'b0;
                  busy         <= 1'b1;
                  cnt          <= SETTLE_LOAD;
                  state        <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt == 4'd0) state <= CHECK;
               else             cnt   <= cnt - 4'd1;
            end
            CHECK: begin
               if (mismatch) begin
                  err_count         <= err_next;
                  err_vec           <= err_vec | diff;
                  fail_pattern[idx] <= 1'b1;
               end
               if (idx != 2'd3) begin
                  idx            <= idx + 2'd1;
                  {a_out, b_out} <= idx + 2'd1;
                  cnt            <= SETTLE_LOAD;
                  state          <= SETTLE;
               end else begin
                  // Registered so that done, pass and idle inputs all appear in the FINISH cycle.
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  pass  <= (err_next == 3'd0);
                  a_out <= 1'b0;
                  b_out <= 1'b0;
                  state <= FINISH;
               end
            end
            FINISH: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_bist_checker.sv
// tb/tb_gate_bist_checker.sv - directed table-driven bench for gate_bist_checker
module tb_gate_bist_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start0 = 1'b0, start1 = 1'b0;
   logic [6:0] stuck = 7'd0, flip = 7'd0;

   logic       a0, b0, busy0, done0, pass0;
   logic [2:0] ec0;
   logic [6:0] ev0, y0;
   logic [3:0] fp0;
   logic       a1, b1, busy1, done1, pass1;
   logic [2:0] ec1;
   logic [6:0] ev1, y1;
   logic [3:0] fp1;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [6:0] stk;
      logic [6:0] flp;
      logic [2:0] ec;
      logic [6:0] ev;
      logic [3:0] fp;
      logic       ps;
   } vec_t;

   vec_t tbl[7];

   always #5 clk = ~clk;

   function automatic logic [6:0] gate_model(input logic a, input logic b);
      logic [6:0] y;
      y[0] = a & b;
      y[1] = a | b;
      y[2] = ~(a & b);
      y[3] = ~(a | b);
      y[4] = a ^ b;
      y[5] = ~(a ^ b);
      y[6] = ~a;
      return y;
   endfunction

   always_comb y0 = (gate_model(a0, b0) & ~stuck) ^ flip;
   always_comb y1 = gate_model(a1, b1);

   gate_bist_checker #(.SETTLE_CYCLES(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .a_out(a0), .b_out(b0), .y_in(y0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0), .err_vec(ev0),
      .fail_pattern(fp0)
   );

   gate_bist_checker #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1), .y_in(y1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1), .err_vec(ev1),
      .fail_pattern(fp1)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_start(input int sel, input logic v);
      if (sel == 0) start0 = v;
      else          start1 = v;
   endtask

   task automatic chk_results(input int sel, input string tag, input logic [2:0] ec,
                              input logic [6:0] ev, input logic [3:0] fp, input logic ps);
      chk({tag, "_err_count"}, int'(sel == 0 ? ec0 : ec1), int'(ec));
      chk({tag, "_err_vec"},   int'(sel == 0 ? ev0 : ev1), int'(ev));
      chk({tag, "_fail_pat"},  int'(sel == 0 ? fp0 : fp1), int'(fp));
      chk({tag, "_pass"},      int'(sel == 0 ? pass0 : pass1), int'(ps));
   endtask

   // One full run: a/b stepping, busy and the single done pulse are checked every cycle.
   task automatic run(input int sel, input int s, input vec_t v, input bit repulse);
      int         len;
      logic [1:0] exp_ab;
      logic [1:0] act_ab;
      len   = 4 * (s + 1);
      stuck = v.stk;
      flip  = v.flp;
      @(posedge clk); #1 set_start(sel, 1'b1);
      @(posedge clk); #1 set_start(sel, 1'b0);
      for (int k = 0; k <= len + 3; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         exp_ab = (k < len) ? 2'(k / (s + 1)) : 2'd0;
         act_ab = (sel == 0) ? {a0, b0} : {a1, b1};
         chk("ab", int'(act_ab), int'(exp_ab));
         chk("busy", int'(sel == 0 ? busy0 : busy1), int'(k < len));
         chk("done", int'(sel == 0 ? done0 : done1), int'(k == len));
         if (k == len) begin
            chk_results(sel, "end", v.ec, v.ev, v.fp, v.ps);
            stuck = 7'h00;
            flip  = 7'h7f;
         end
         set_start(sel, repulse && (k + 1 == 3 || k + 1 == len));
      end
      set_start(sel, 1'b0);
      chk_results(sel, "hold", v.ec, v.ev, v.fp, v.ps);
      flip = 7'h00;
   endtask

   initial begin
      tbl[0] = '{7'h00, 7'h00, 3'd0, 7'b0000000, 4'b0000, 1'b1};
      tbl[1] = '{7'h01, 7'h00, 3'd1, 7'b0000001, 4'b1000, 1'b0};
      tbl[2] = '{7'h00, 7'h40, 3'd4, 7'b1000000, 4'b1111, 1'b0};
      tbl[3] = '{7'h04, 7'h00, 3'd3, 7'b0000100, 4'b0111, 1'b0};
      tbl[4] = '{7'h08, 7'h00, 3'd1, 7'b0001000, 4'b0001, 1'b0};
      tbl[5] = '{7'h00, 7'h12, 3'd4, 7'b0010010, 4'b1111, 1'b0};
      tbl[6] = '{7'h20, 7'h00, 3'd2, 7'b0100000, 4'b1001, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ab", int'({a0, b0}), 0);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_done", int'(done0), 0);
      chk_results(0, "rst", 3'd0, 7'd0, 4'd0, 1'b0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run(0, 2, tbl[i], 1'b0);

      // Start re-pulsed mid-run and on the done edge must not restart the run.
      run(0, 2, tbl[0], 1'b1);

      // Fast settle variant.
      run(1, 1, tbl[0], 1'b0);

      // Reset in the middle of a failing run aborts it without a done pulse.
      stuck = 7'h7f;
      @(posedge clk); #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_ab", int'({a0, b0}), 0);
      chk("abort_busy", int'(busy0), 0);
      chk_results(0, "abort", 3'd0, 7'd0, 4'd0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_done", int'(done0), 0);
      end
      rst_n = 1'b1;
      stuck = 7'h00;
      run(0, 2, tbl[0], 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
